// File: rtl/uart_rx_fifo.sv
// UART receiver with first-word-fall-through RX FIFO, sticky error flags and interrupt request.
// Optional: define UART_RX_TIMEOUT_EN to add an idle-timeout term to o_irq.
module uart_rx_fifo #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 2_000_000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 4,
    parameter int IRQ_LEVEL   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx,
    input  logic                          i_rd,
    input  logic                          i_clr_err,
    output logic [DATA_BITS-1:0]          o_data,
    output logic                          o_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overrun,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_irq
);

    localparam int B  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW = $clog2(B + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [CW-1:0] HALF_C   = CW'(B / 2);
    localparam logic [CW-1:0] FULL_C   = CW'(B);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [LW-1:0] DEPTH_C  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] IRQ_C    = LW'(IRQ_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    logic                 rx_meta, rx_sync, rx_prev;
    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 par_bad, par_bad_n;
    logic                 push, pop, room, exp_par;
    logic                 set_ovr, set_fe, set_pe, timeout_term;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    // NOTE: every register uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
            par_bad <= par_bad_n;
        end
    end

    assign o_valid = (o_level != '0);
    assign pop     = i_rd & o_valid;
    assign room    = (o_level != DEPTH_C) | pop;
    assign exp_par = (PARITY_MODE == 2) ? ~(^shreg) : (^shreg);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_n     = bit_idx;
        sh_n      = shreg;
        par_bad_n = par_bad;
        push      = 1'b0;
        set_ovr   = 1'b0;
        set_fe    = 1'b0;
        set_pe    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n     = CW'(1);
                par_bad_n = 1'b0;
                if (rx_prev && !rx_sync) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_C) begin
                    cnt_n   = CW'(1);
                    bit_n   = '0;
                    state_n = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == FULL_C) begin
                    cnt_n = CW'(1);
                    sh_n  = {rx_sync, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    else                     bit_n   = bit_idx + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt == FULL_C) begin
                    cnt_n   = CW'(1);
                    state_n = S_STOP;
                    if (rx_sync != exp_par) begin
                        set_pe    = 1'b1;
                        par_bad_n = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (cnt == FULL_C) begin
                    if (rx_sync) begin
                        state_n = S_IDLE;
                        if (!par_bad) begin
                            push    = room;
                            set_ovr = ~room;
                        end
                    end else begin
                        set_fe  = 1'b1;
                        state_n = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: if (rx_sync) state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; o_data is masked while empty instead.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    assign o_data = o_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   o_level <= o_level + 1'b1;
                2'b01:   o_level <= o_level - 1'b1;
                default: o_level <= o_level;
            endcase
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO = 4 * (DATA_BITS + 2) * B;
    localparam int TW = $clog2(TO + 1);
    localparam logic [TW-1:0] TO_C = TW'(TO);

    logic [TW-1:0] to_cnt;
    logic          timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (push || pop)                                          to_cnt <= '0;
            else if (o_valid && state == S_IDLE && to_cnt != TO_C)    to_cnt <= to_cnt + 1'b1;
            if (pop || !o_valid)     timeout <= 1'b0;
            else if (to_cnt == TO_C) timeout <= 1'b1;
        end
    end

    assign timeout_term = timeout;
`else
    assign timeout_term = 1'b0;
`endif

    // Clear loses to a same-cycle set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun    <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_irq        <= 1'b0;
        end else begin
            o_overrun    <= set_ovr | (o_overrun    & ~i_clr_err);
            o_frame_err  <= set_fe  | (o_frame_err  & ~i_clr_err);
            o_parity_err <= set_pe  | (o_parity_err & ~i_clr_err);
            o_irq        <= (o_level >= IRQ_C) | o_overrun | o_frame_err | o_parity_err | timeout_term;
        end
    end

endmodule
